// File: rtl/pc_sequencer.sv
// Fetch/issue program-counter sequencer: fetches one instruction, issues it, then waits for its next-PC resolution.
// Optional feature macro PC_MISALIGN_TRAP_EN: trap on misaligned branch/jalr targets instead of silently aligning them.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_prePCSrc,
    input  logic        i_resolve,
    input  logic [31:0] i_branchTarget,
    input  logic [31:0] i_jalrTarget,
    input  logic [31:0] i_trapVector,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    output logic        o_instValid,
    output logic [31:0] o_inst,
    output logic [31:0] o_instPC,
    input  logic        i_stall,
    output logic [31:0] o_mepc,
    output logic        o_trapTaken,
    output logic        o_misalign
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_RES = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_d, inst_pc_d, mepc_d;
    logic [XLEN-1:0] jump_raw, jump_tgt;
    logic            jump_bad;
    logic            req_d, valid_d, trap_d, misalign_d;

    // The fetch address is the PC register itself.
    assign o_imemAddr = pc_q;

    // Branch/jalr target selection and alignment handling
    always_comb begin
        jump_raw = (i_prePCSrc == 2'b11) ? (i_jalrTarget & ~XLEN'(1)) : i_branchTarget;
`ifdef PC_MISALIGN_TRAP_EN
        jump_tgt = jump_raw;
        jump_bad = (jump_raw[1:0] != 2'b00);
`else
        jump_tgt = jump_raw & ~XLEN'(3);
        jump_bad = 1'b0;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = 1'b0;
        valid_d    = 1'b0;
        inst_d     = o_inst;
        inst_pc_d  = o_instPC;
        mepc_d     = o_mepc;
        trap_d     = 1'b0;
        misalign_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                req_d = 1'b1;
                if (i_imemAck) begin
                    state_d   = ISSUE;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    inst_d    = i_imemData;
                    inst_pc_d = pc_q;
                end
            end
            ISSUE: begin
                valid_d = 1'b1;
                if (!i_stall) begin
                    state_d = WAIT_RES;
                    valid_d = 1'b0;
                end
            end
            WAIT_RES: begin
                if (i_resolve) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    unique case (i_prePCSrc)
                        2'b00: pc_d = pc_q + XLEN'(4);
                        2'b10: begin
                            pc_d   = i_trapVector;
                            mepc_d = o_instPC;
                            trap_d = 1'b1;
                        end
                        default: begin
                            if (jump_bad) begin
                                pc_d       = i_trapVector;
                                mepc_d     = o_instPC;
                                trap_d     = 1'b1;
                                misalign_d = 1'b1;
                            end else begin
                                pc_d = jump_tgt;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            o_imemReq   <= 1'b0;
            o_instValid <= 1'b0;
            o_inst      <= '0;
            o_instPC    <= '0;
            o_mepc      <= '0;
            o_trapTaken <= 1'b0;
            o_misalign  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            o_imemReq   <= req_d;
            o_instValid <= valid_d;
            o_inst      <= inst_d;
            o_instPC    <= inst_pc_d;
            o_mepc      <= mepc_d;
            o_trapTaken <= trap_d;
            o_misalign  <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level PC model plus a per-cycle output compare.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int P_RST   = 0;
    localparam int P_IDLE  = 1;
    localparam int P_FETCH = 2;
    localparam int P_ISSUE = 3;
    localparam int P_WAIT  = 4;

    logic        clk;
    logic        i_rst_n;
    logic [1:0]  i_prePCSrc;
    logic        i_resolve;
    logic [31:0] i_branchTarget, i_jalrTarget, i_trapVector;
    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        i_imemAck;
    logic [31:0] i_imemData;
    logic        o_instValid;
    logic [31:0] o_inst, o_instPC;
    logic        i_stall;
    logic [31:0] o_mepc;
    logic        o_trapTaken, o_misalign;

    // Reference model state
    int          phase;
    logic [31:0] exp_pc, exp_inst, exp_ipc, exp_mepc;
    logic        exp_trap, exp_mis;
    int          n_checks, n_fail;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_prePCSrc     (i_prePCSrc),
        .i_resolve      (i_resolve),
        .i_branchTarget (i_branchTarget),
        .i_jalrTarget   (i_jalrTarget),
        .i_trapVector   (i_trapVector),
        .o_imemReq      (o_imemReq),
        .o_imemAddr     (o_imemAddr),
        .i_imemAck      (i_imemAck),
        .i_imemData     (i_imemData),
        .o_instValid    (o_instValid),
        .o_inst         (o_inst),
        .o_instPC       (o_instPC),
        .i_stall        (i_stall),
        .o_mepc         (o_mepc),
        .o_trapTaken    (o_trapTaken),
        .o_misalign     (o_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (phase == P_RST) begin
            check1("rst_req", o_imemReq, 1'b0);
            check1("rst_valid", o_instValid, 1'b0);
            check("rst_addr", o_imemAddr, RESET_PC);
            check("rst_inst", o_inst, 32'h0);
            check("rst_instpc", o_instPC, 32'h0);
            check("rst_mepc", o_mepc, 32'h0);
            check1("rst_trap", o_trapTaken, 1'b0);
            check1("rst_mis", o_misalign, 1'b0);
        end else begin
            check1("req", o_imemReq, phase == P_FETCH);
            check1("valid", o_instValid, phase == P_ISSUE);
            check1("req_valid_excl", o_imemReq & o_instValid, 1'b0);
            if (phase == P_FETCH) check("fetch_addr", o_imemAddr, exp_pc);
            if (phase == P_ISSUE) begin
                check("issue_inst", o_inst, exp_inst);
                check("issue_pc", o_instPC, exp_ipc);
            end
            check("mepc", o_mepc, exp_mepc);
            check1("trap", o_trapTaken, exp_trap);
            check1("misalign", o_misalign, exp_mis);
        end
    end

    // One clock; pulse expectations last a single cycle
    task automatic step();
        @(posedge clk);
        #1;
        exp_trap = 1'b0;
        exp_mis  = 1'b0;
    endtask

    task automatic do_reset(input bit late_ack);
        i_rst_n   = 1'b0;
        i_imemAck = 1'b0;
        i_resolve = 1'b0;
        i_stall   = 1'b0;
        phase     = P_RST;
        exp_pc    = RESET_PC;
        exp_mepc  = 32'h0;
        step();
        step();
        i_rst_n    = 1'b1;
        i_imemAck  = late_ack;
        i_imemData = $urandom;
        phase      = P_IDLE;
        step();
        i_imemAck = 1'b0;
        phase     = P_FETCH;
    endtask

    task automatic fetch(input int delay, input logic [31:0] data);
        repeat (delay) step();
        i_imemAck  = 1'b1;
        i_imemData = data;
        i_stall    = 1'b0;
        step();
        i_imemAck  = 1'b0;
        i_imemData = $urandom;
        exp_inst   = data;
        exp_ipc    = exp_pc;
        phase      = P_ISSUE;
    endtask

    task automatic issue(input int stalls, input bit spurious);
        for (int k = 0; k < stalls; k++) begin
            i_stall        = 1'b1;
            i_resolve      = spurious && (k == 0);
            i_prePCSrc     = 2'($urandom);
            i_branchTarget = $urandom;
            i_trapVector   = $urandom;
            step();
        end
        i_stall   = 1'b0;
        i_resolve = 1'b0;
        step();
        phase = P_WAIT;
    endtask

    task automatic resolve(input int idle, input logic [1:0] src, input logic [31:0] br,
                           input logic [31:0] jr, input logic [31:0] tv);
        logic [31:0] t;
        bit          trap_now, mis_now;
        repeat (idle) begin
            i_imemAck  = 1'($urandom);
            i_imemData = $urandom;
            i_stall    = 1'($urandom);
            step();
        end
        i_imemAck      = 1'b0;
        i_stall        = 1'b0;
        i_resolve      = 1'b1;
        i_prePCSrc     = src;
        i_branchTarget = br;
        i_jalrTarget   = jr;
        i_trapVector   = tv;
        step();
        i_resolve = 1'b0;
        trap_now  = 1'b0;
        mis_now   = 1'b0;
        case (src)
            2'b00: exp_pc = exp_pc + 32'd4;
            2'b10: trap_now = 1'b1;
            default: begin
                t = (src == 2'b11) ? jr - (jr % 32'd2) : br;
`ifdef PC_MISALIGN_TRAP_EN
                if (t % 32'd4 != 32'd0) begin
                    trap_now = 1'b1;
                    mis_now  = 1'b1;
                end else begin
                    exp_pc = t;
                end
`else
                exp_pc = t - (t % 32'd4);
`endif
            end
        endcase
        if (trap_now) begin
            exp_pc   = tv;
            exp_mepc = exp_ipc;
        end
        exp_trap = trap_now;
        exp_mis  = mis_now;
        phase    = P_FETCH;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 5) != 0) v = v & ~32'd3;
        return v;
    endfunction

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        phase          = P_RST;
        i_rst_n        = 1'b0;
        i_prePCSrc     = 2'b00;
        i_resolve      = 1'b0;
        i_branchTarget = 32'h0;
        i_jalrTarget   = 32'h0;
        i_trapVector   = 32'h0;
        i_imemAck      = 1'b0;
        i_imemData     = 32'h0;
        i_stall        = 1'b0;
        exp_pc         = RESET_PC;
        exp_inst       = 32'h0;
        exp_ipc        = 32'h0;
        exp_mepc       = 32'h0;
        exp_trap       = 1'b0;
        exp_mis        = 1'b0;

        do_reset(1'b0);
        check("boot_addr", o_imemAddr, RESET_PC);
        fetch(2, 32'h0000_0013);
        check("boot_inst", o_inst, 32'h0000_0013);
        check("boot_instpc", o_instPC, RESET_PC);
        issue(3, 1'b1);
        resolve(1, 2'b01, 32'h100, 32'h0, 32'h0);
        check1("branch_req", o_imemReq, 1'b1);
        check("branch_addr", o_imemAddr, 32'h100);

        fetch(0, $urandom);
        issue(0, 1'b0);
        resolve(0, 2'b01, 32'h40, 32'h0, 32'h0);
        fetch(1, $urandom);
        issue(1, 1'b0);
        resolve(0, 2'b10, 32'h0, 32'h0, 32'h200);
        check("ecall_mepc", o_mepc, 32'h40);
        check1("ecall_trap", o_trapTaken, 1'b1);
        check("ecall_addr", o_imemAddr, 32'h200);
        step();
        check1("ecall_trap_drop", o_trapTaken, 1'b0);

        fetch(0, $urandom);
        issue(0, 1'b0);
        resolve(0, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0);
        fetch(0, $urandom);
        issue(0, 1'b0);
        resolve(0, 2'b00, 32'h0, 32'h0, 32'h0);
        check("wrap_addr", o_imemAddr, 32'h0);
        fetch(0, $urandom);
        issue(0, 1'b0);
        resolve(0, 2'b11, 32'h0, 32'h101, 32'h0);
        check("jalr_addr", o_imemAddr, 32'h100);

        fetch(0, $urandom);
        issue(2, 1'b1);
        resolve(0, 2'b01, 32'h102, 32'h0, 32'h300);
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_addr", o_imemAddr, 32'h300);
        check1("misalign_pulse", o_misalign, 1'b1);
`else
        check("misalign_addr", o_imemAddr, 32'h100);
        check1("misalign_pulse", o_misalign, 1'b0);
`endif

        // Reset mid-fetch with a late ack, then mid-issue
        step();
        do_reset(1'b1);
        fetch(1, $urandom);
        do_reset(1'b0);

        for (int n = 0; n < 60; n++) begin
            fetch($urandom_range(0, 3), $urandom);
            issue($urandom_range(0, 3), 1'($urandom));
            resolve($urandom_range(0, 2), 2'($urandom), rand_target(), rand_target(), $urandom);
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
